// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// CPU and DMA request groups plus the single RAM port of the stage-three data memory arbiter.
// slave = arbiter side; master = requesters and RAM side.
interface dmem_arbiter_if #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
);
  logic               cpu_req;
  logic               cpu_we;
  logic [A_WIDTH-1:0] cpu_addr;
  logic [D_WIDTH-1:0] cpu_wdata;
  logic [D_WIDTH-1:0] cpu_rdata;
  logic               cpu_done;
  logic               d_odv;

  logic               dma_req;
  logic               dma_we;
  logic [A_WIDTH-1:0] dma_addr;
  logic [D_WIDTH-1:0] dma_wdata;
  logic [D_WIDTH-1:0] dma_rdata;
  logic               dma_done;

  logic [A_WIDTH-1:0] ram_addr;
  logic [D_WIDTH-1:0] ram_wdata;
  logic               ram_we;
  logic               ram_re;
  logic [D_WIDTH-1:0] ram_rdata;
  logic               busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, d_odv,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output ram_addr, ram_wdata, ram_we, ram_re, busy,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, d_odv,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  ram_addr, ram_wdata, ram_we, ram_re, busy,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// CPU/DMA arbiter for the 256x8 data RAM: write done 2 cycles, read done 3 cycles after the IDLE sample.
// No backpressure: requesters hold req until their done pulse; DMEM_ARB_RR_EN selects round-robin ties over fixed CPU priority.
module dmem_arbiter #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
`ifndef DMEM_ARB_RR_EN
  ,
  parameter int STARVE_LIMIT = 3
`endif
) (
  input  logic          g_clk,
  input  logic          g_clr,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               owner;
  logic               grant_vld;
  logic               grant_dma;
  logic               arb_en;
  logic               lat_we;
  logic [A_WIDTH-1:0] lat_addr;
  logic [D_WIDTH-1:0] lat_wdata;
  logic [D_WIDTH-1:0] cpu_rdata_q;
  logic [D_WIDTH-1:0] dma_rdata_q;

  assign grant_vld = bus.cpu_req | bus.dma_req;
  assign arb_en    = (state == S_IDLE) && grant_vld;

`ifdef DMEM_ARB_RR_EN
  // Remembers who was served last; reset says DMA so the CPU takes the first tie.
  logic rr_last_dma;

  always_comb begin
    grant_dma = bus.dma_req;
    if (bus.cpu_req && bus.dma_req) begin
      grant_dma = !rr_last_dma;
    end
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      rr_last_dma <= 1'b1;
    end else if (arb_en) begin
      rr_last_dma <= grant_dma;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_comb begin
    grant_dma = bus.dma_req;
    if (bus.cpu_req && bus.dma_req) begin
      grant_dma = (starve_cnt == LIMIT);
    end
  end

  // Counts ties the DMA lost since its last grant; saturates so the escape stays armed.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      starve_cnt <= 4'd0;
    end else if (arb_en && bus.dma_req) begin
      if (grant_dma) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_we ? S_DONE : S_WAIT;
      S_WAIT:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state     <= S_IDLE;
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (arb_en) begin
        owner     <= grant_dma ? OWN_DMA : OWN_CPU;
        lat_we    <= grant_dma ? bus.dma_we    : bus.cpu_we;
        lat_addr  <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
        lat_wdata <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
      end
    end
  end

  // Read data lands one cycle after the strobe, so WAIT's exiting edge is the capture point.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (state == S_WAIT) begin
      if (owner == OWN_DMA) begin
        dma_rdata_q <= bus.ram_rdata;
      end else begin
        cpu_rdata_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_addr  = lat_addr;
  assign bus.ram_wdata = lat_wdata;
  assign bus.ram_we    = (state == S_ISSUE) &&  lat_we;
  assign bus.ram_re    = (state == S_ISSUE) && !lat_we;
  assign bus.busy      = (state != S_IDLE);

  assign bus.cpu_done  = (state == S_DONE) && (owner == OWN_CPU);
  assign bus.dma_done  = (state == S_DONE) && (owner == OWN_DMA);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

  // Stall qualifier for the controller: low while a CPU access is outstanding.
  assign bus.d_odv     = !bus.cpu_req || bus.cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_arbiter: randomized CPU/DMA traffic against a transaction-level memory model.
module tb_dmem_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int LIMIT = 3;
  localparam int NC    = 10;
  localparam int ND    = 3;

  typedef struct {
    bit         dma;
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic g_clk = 1'b0;
  logic g_clr;
  always #5 g_clk = ~g_clk;

  dmem_arbiter_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  dmem_arbiter dut (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .bus   (bus)
  );

  logic [7:0] mem       [256];
  logic [7:0] model_mem [256];
  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cpu_rd = '0;
  logic [7:0] exp_dma_rd = '0;

  bit         c_we [NC];
  logic [7:0] c_addr [NC];
  logic [7:0] c_wd [NC];
  bit         d_we [ND];
  logic [7:0] d_addr [ND];
  logic [7:0] d_wd [ND];

  // RAM behind the arbiter: read data appears the cycle after the strobe.
  always @(posedge g_clk) begin
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_access(input bit dma, input bit we, input logic [7:0] addr, input logic [7:0] wd);
    exp_t e;
    e.dma  = dma;
    e.we   = we;
    e.addr = addr;
    if (we) begin
      model_mem[addr] = wd;
      e.data = wd;
    end else begin
      e.data = model_mem[addr];
    end
    sb.push_back(e);
  endtask

  always @(negedge g_clk) begin : monitor
    exp_t e;
    if (!g_clr) begin
      exp_cpu_rd = '0;
      exp_dma_rd = '0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_ram_strobes", {bus.ram_we, bus.ram_re}, 0);
      chk("rst_dones", {bus.cpu_done, bus.dma_done}, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_dma_rdata", bus.dma_rdata, 0);
      chk("rst_d_odv", bus.d_odv, !bus.cpu_req);
    end else begin
      if (bus.cpu_done && bus.dma_done) begin
        chk("single_done", {bus.cpu_done, bus.dma_done}, 2'b01);
      end else if (bus.cpu_done || bus.dma_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done_qlen", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("done_owner", bus.dma_done, e.dma);
          chk("done_addr", bus.ram_addr, e.addr);
          if (e.we) chk("ram_written", mem[e.addr], e.data);
          else if (e.dma) exp_dma_rd = e.data;
          else exp_cpu_rd = e.data;
        end
      end
      chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
      chk("dma_rdata", bus.dma_rdata, exp_dma_rd);
      chk("d_odv", bus.d_odv, !bus.cpu_req || bus.cpu_done);
    end
  end

  // Single access with the arbiter idle; call at #1 after a rising edge.
  task automatic do_access(input bit dma, input bit we, input logic [7:0] addr, input logic [7:0] wd, input bit keep);
    int cyc;
    int strobe_cyc;
    int strobes;
    bit got;
    cyc = 0; strobe_cyc = -1; strobes = 0; got = 0;
    if (dma) begin
      bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd; bus.dma_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
    end
    expect_access(dma, we, addr, wd);
    while (!got && cyc < 20) begin
      @(negedge g_clk);
      chk("busy", bus.busy, cyc != 0);
      if (bus.ram_we || bus.ram_re) begin
        strobes++;
        strobe_cyc = cyc;
        chk("strobe_kind", bus.ram_we, we);
        chk("strobe_addr", bus.ram_addr, addr);
        if (we) chk("strobe_wdata", bus.ram_wdata, wd);
      end
      if (dma ? bus.dma_done : bus.cpu_done) got = 1'b1;
      else cyc++;
    end
    chk("done_latency", cyc, we ? 2 : 3);
    chk("strobe_cycle", strobe_cyc, 1);
    chk("strobe_count", strobes, 1);
    @(posedge g_clk); #1;
    if (!keep) begin
      if (dma) bus.dma_req = 1'b0;
      else bus.cpu_req = 1'b0;
    end
  endtask

  // Requester that re-requests immediately after each of its done pulses.
  task automatic run_list(input bit dma, input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      int w;
      got = 0; w = 0;
      if (dma) begin
        bus.dma_we = d_we[i]; bus.dma_addr = d_addr[i]; bus.dma_wdata = d_wd[i]; bus.dma_req = 1'b1;
      end else begin
        bus.cpu_we = c_we[i]; bus.cpu_addr = c_addr[i]; bus.cpu_wdata = c_wd[i]; bus.cpu_req = 1'b1;
      end
      while (!got && w < 300) begin
        @(negedge g_clk);
        w++;
        got = dma ? bus.dma_done : bus.cpu_done;
      end
      chk(dma ? "dma_grant_wait" : "cpu_grant_wait", got, 1);
      @(posedge g_clk); #1;
    end
    if (dma) bus.dma_req = 1'b0;
    else bus.cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    g_clr = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 g_clr = 1'b1;
    @(posedge g_clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
    $fatal(1);
  end

  initial begin : stim
    int ci;
    int di;
    int k;
    bit dwin;
    g_clr = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      model_mem[i] = mem[i];
    end
    mem[8'h3F] = 8'h5C;
    model_mem[8'h3F] = 8'h5C;

    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    g_clr = 1'b1;
    @(posedge g_clk); #1;

    // CPU write then read back, DMA-only read, back-to-back held CPU request
    do_access(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
    do_access(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    do_access(1'b1, 1'b0, 8'h3F, 8'h00, 1'b0);
    do_access(1'b0, 1'b0, 8'h10, 8'h00, 1'b1);
    do_access(1'b0, 1'b1, 8'h11, 8'h3C, 1'b1);
    do_access(1'b0, 1'b0, 8'h11, 8'h00, 1'b0);

    // Randomized single-requester traffic over a small address window
    for (int i = 0; i < 24; i++) begin
      do_access(1'($urandom), 1'($urandom), 8'(8'h20 + $urandom_range(0, 7)), 8'($urandom), 1'b0);
    end

    // Reset while a CPU read sits in WAIT: abandoned, no done pulse
    bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10; bus.cpu_req = 1'b1;
    @(posedge g_clk);
    @(posedge g_clk);
    #2 g_clr = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ram_re", bus.ram_re, 0);
    chk("midrst_cpu_done", bus.cpu_done, 0);
    chk("midrst_cpu_rdata", bus.cpu_rdata, 0);
    chk("midrst_ram_addr", bus.ram_addr, 0);
    chk("midrst_d_odv", bus.d_odv, 0);
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 g_clr = 1'b1;
    @(posedge g_clk); #1;
    do_access(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);

    // Contention from a clean arbitration state
    do_reset();
    for (int i = 0; i < NC; i++) begin
      c_we[i] = 1'($urandom); c_addr[i] = 8'(8'h20 + $urandom_range(0, 7)); c_wd[i] = 8'($urandom);
    end
    for (int i = 0; i < ND; i++) begin
      d_we[i] = 1'($urandom); d_addr[i] = 8'(8'h20 + $urandom_range(0, 7)); d_wd[i] = 8'($urandom);
    end
    ci = 0; di = 0; k = 0;
    while (ci < NC || di < ND) begin
      if (ci < NC && di < ND) begin
`ifdef DMEM_ARB_RR_EN
        dwin = (k % 2) == 1;
`else
        dwin = (k % (LIMIT + 1)) == LIMIT;
`endif
        k++;
      end else begin
        dwin = (di < ND);
      end
      if (dwin) begin
        expect_access(1'b1, d_we[di], d_addr[di], d_wd[di]);
        di++;
      end else begin
        expect_access(1'b0, c_we[ci], c_addr[ci], c_wd[ci]);
        ci++;
      end
    end
    fork
      run_list(1'b0, NC);
      run_list(1'b1, ND);
    join

    repeat (4) @(posedge g_clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("idle_at_end", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
